// File: rtl/nearest_pkg.sv
// nearest_pkg: shared types for the nearest-value search block.
//   state_t : search FSM state encoding (IDLE, SCAN, DONE)
// Optional build macro (used by abs_dist): NEAREST_SIGNED_EN selects
// two's-complement operands instead of unsigned operands.
package nearest_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nearest_abs_dist.sv
// abs_dist: combinational absolute distance |a - b| at W+1 bits.
// This module is the single distance definition shared with the two-input selector.
//   a, b : W-bit operands
//   d    : W+1-bit distance, range 0 .. 2^W-1
// Macro NEAREST_SIGNED_EN: when defined, a and b are two's complement and
// are sign-extended. When it is undefined, a and b are zero-extended.
module abs_dist #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   d
);

  logic [W:0] ea, eb, diff;

`ifdef NEAREST_SIGNED_EN
  assign ea = {a[W-1], a};
  assign eb = {b[W-1], b};
`else
  assign ea = {1'b0, a};
  assign eb = {1'b0, b};
`endif

  // The true difference always lies within +/-(2^W-1). It therefore fits a
  // W+1-bit two's-complement value, and its magnitude fits W+1 bits unsigned.
  assign diff = ea - eb;
  assign d    = diff[W] ? (-diff) : diff;

endmodule

// File: rtl/nearest_search.sv
// nearest_search: latches a reference value and scans N candidates over a
// valid/ready stream. It then returns the closest candidate, its arrival
// index and its distance through a held result handshake.
//   clk, reset      : clock and synchronous active-high reset
//   start, reff     : begin a search (honoured in IDLE only) and its reference
//   busy            : high while a search is in SCAN or DONE
//   cand_valid/ready/data : candidate stream (ready high only in SCAN)
//   result_valid/ready    : result handshake (valid held until accepted)
//   result_data/idx/dist  : closest value, its index, and |value - reff|
// Macro NEAREST_SIGNED_EN (handled in abs_dist): signed operands.
import nearest_pkg::*;

module nearest_search #(
  parameter  int W  = 8,
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  reff,
  output logic          busy,
  input  logic          cand_valid,
  output logic          cand_ready,
  input  logic [W-1:0]  cand_data,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [W-1:0]  result_data,
  output logic [IW-1:0] result_idx,
  output logic [W:0]    result_dist
);

  state_t        state_q, state_d;
  logic [IW-1:0] count_q, count_d;
  logic [W-1:0]  ref_q, ref_d;
  logic [W:0]    best_dist_q, best_dist_d;
  logic [W-1:0]  best_data_q, best_data_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  logic [W:0]    res_dist_q, res_dist_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic [IW-1:0] res_idx_q, res_idx_d;

  logic [W:0]    cand_dist;
  logic          take;
  logic [W:0]    upd_dist;
  logic [W-1:0]  upd_data;
  logic [IW-1:0] upd_idx;

  abs_dist #(.W(W)) u_dist (
    .a (cand_data),
    .b (ref_q),
    .d (cand_dist)
  );

  // The comparison is strict, so on a tie the earlier candidate (lower index) wins.
  // best_dist starts at all-ones, which any first candidate beats.
  assign take     = cand_dist < best_dist_q;
  assign upd_dist = take ? cand_dist : best_dist_q;
  assign upd_data = take ? cand_data : best_data_q;
  assign upd_idx  = take ? count_q   : best_idx_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ref_d       = ref_q;
    best_dist_d = best_dist_q;
    best_data_d = best_data_q;
    best_idx_d  = best_idx_q;
    res_dist_d  = res_dist_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SCAN;
          ref_d       = reff;
          count_d     = '0;
          best_dist_d = '1;
          best_idx_d  = '0;
        end
      end
      SCAN: begin
        if (cand_valid) begin
          count_d     = count_q + IW'(1);
          best_dist_d = upd_dist;
          best_data_d = upd_data;
          best_idx_d  = upd_idx;
          // The result registers load together with the final acceptance,
          // so result_valid and the result values appear on the same cycle.
          if (count_q == IW'(N - 1)) begin
            state_d    = DONE;
            res_dist_d = upd_dist;
            res_data_d = upd_data;
            res_idx_d  = upd_idx;
          end
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ref_q       <= '0;
      best_dist_q <= '1;
      best_data_q <= '0;
      best_idx_q  <= '0;
      res_dist_q  <= '0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ref_q       <= ref_d;
      best_dist_q <= best_dist_d;
      best_data_q <= best_data_d;
      best_idx_q  <= best_idx_d;
      res_dist_q  <= res_dist_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign cand_ready   = (state_q == SCAN);
  assign result_valid = (state_q == DONE);
  assign result_data  = res_data_q;
  assign result_idx   = res_idx_q;
  assign result_dist  = res_dist_q;

endmodule

// File: tb/tb_nearest_search.sv
module tb_nearest_search;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Unit 0: N=4 (directed tests). Unit 1: N=8 (random tests).
  logic       st [2];
  logic       cv [2];
  logic       rr [2];
  logic [7:0] rf [2];
  logic [7:0] cd [2];

  logic       bsy_0, bsy_1, crdy_0, crdy_1, rv_0, rv_1;
  logic [7:0] rd_0, rd_1;
  logic [1:0] ri_0;
  logic [2:0] ri_1;
  logic [8:0] rds_0, rds_1;

  logic       bsy [2];
  logic       crdy [2];
  logic       rv [2];
  logic [7:0] rd [2];
  logic [2:0] ri [2];
  logic [8:0] rds [2];

  assign bsy[0]  = bsy_0;   assign bsy[1]  = bsy_1;
  assign crdy[0] = crdy_0;  assign crdy[1] = crdy_1;
  assign rv[0]   = rv_0;    assign rv[1]   = rv_1;
  assign rd[0]   = rd_0;    assign rd[1]   = rd_1;
  assign ri[0]   = {1'b0, ri_0};
  assign ri[1]   = ri_1;
  assign rds[0]  = rds_0;   assign rds[1]  = rds_1;

  nearest_search #(.W(8), .N(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(st[0]), .reff(rf[0]), .busy(bsy_0),
    .cand_valid(cv[0]), .cand_ready(crdy_0), .cand_data(cd[0]),
    .result_valid(rv_0), .result_ready(rr[0]), .result_data(rd_0),
    .result_idx(ri_0), .result_dist(rds_0)
  );

  nearest_search #(.W(8), .N(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(st[1]), .reff(rf[1]), .busy(bsy_1),
    .cand_valid(cv[1]), .cand_ready(crdy_1), .cand_data(cd[1]),
    .result_valid(rv_1), .result_ready(rr[1]), .result_data(rd_1),
    .result_idx(ri_1), .result_dist(rds_1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // The task starts a search from IDLE, then feeds n candidates with gap stall cycles between them.
  // It returns one cycle after the final acceptance, when result_valid is due.
  task automatic search(input int u, input logic [7:0] r, input logic [7:0] c [8],
                        input int n, input int gap);
    st[u] = 1'b1; rf[u] = r;
    tick();
    st[u] = 1'b0;
    chk("busy_scan", 32'(bsy[u]), 32'd1);
    for (int k = 0; k < n; k++) begin
      chk("cand_ready", 32'(crdy[u]), 32'd1);
      cv[u] = 1'b1; cd[u] = c[k];
      tick();
      cv[u] = 1'b0; cd[u] = 8'hAA;
      chk("rv_timing", 32'(rv[u]), (k == n - 1) ? 32'd1 : 32'd0);
      if (k < n - 1) for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic expect_res(input int u, input string tag, input logic [7:0] d,
                            input logic [2:0] i, input logic [8:0] ds);
    chk({tag, "_valid"}, 32'(rv[u]), 32'd1);
    chk({tag, "_data"},  32'(rd[u]), 32'(d));
    chk({tag, "_idx"},   32'(ri[u]), 32'(i));
    chk({tag, "_dist"},  32'(rds[u]), 32'(ds));
  endtask

  task automatic release_res(input int u);
    rr[u] = 1'b1;
    tick();
    rr[u] = 1'b0;
    chk("rv_drop", 32'(rv[u]), 32'd0);
    chk("busy_idle", 32'(bsy[u]), 32'd0);
  endtask

  function automatic logic [8:0] mdist(input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
`ifdef NEAREST_SIGNED_EN
    ia = $signed(a); ib = $signed(b);
`else
    ia = int'(a); ib = int'(b);
`endif
    return (ia > ib) ? 9'(ia - ib) : 9'(ib - ia);
  endfunction

  initial begin
    logic [7:0] v [8];
    logic [7:0] ed, r;
    logic [2:0] ei;
    logic [8:0] eds, dd;

    for (int u = 0; u < 2; u++) begin
      st[u] = 0; cv[u] = 0; rr[u] = 0; rf[u] = 0; cd[u] = 0;
    end
    tick(); tick();
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk("rst_busy", 32'(bsy[u]), 0);
      chk("rst_crdy", 32'(crdy[u]), 0);
      chk("rst_rv",   32'(rv[u]), 0);
      chk("rst_data", 32'(rd[u]), 0);
      chk("rst_idx",  32'(ri[u]), 0);
      chk("rst_dist", 32'(rds[u]), 0);
    end

    // 1: basic search
    v = '{8'd90, 8'd115, 8'd102, 8'd99, 8'd0, 8'd0, 8'd0, 8'd0};
    search(0, 8'd100, v, 4, 0);
    expect_res(0, "t1", 8'd99, 3'd3, 9'd1);
    release_res(0);

    // 2: ties keep the earlier candidate
    v = '{8'd45, 8'd55, 8'd60, 8'd70, 8'd0, 8'd0, 8'd0, 8'd0};
    search(0, 8'd50, v, 4, 0);
    expect_res(0, "t2a", 8'd45, 3'd0, 9'd5);
    release_res(0);
    v = '{8'd70, 8'd55, 8'd45, 8'd60, 8'd0, 8'd0, 8'd0, 8'd0};
    search(0, 8'd50, v, 4, 0);
    expect_res(0, "t2b", 8'd55, 3'd1, 9'd5);
    release_res(0);

    // 3: extremes
`ifdef NEAREST_SIGNED_EN
    v = '{8'hFF, 8'h02, 8'h80, 8'h7F, 8'd0, 8'd0, 8'd0, 8'd0};
    search(0, 8'd0, v, 4, 0);
    expect_res(0, "t3s", 8'hFF, 3'd0, 9'd1);
`else
    v = '{8'd255, 8'd200, 8'd128, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
    search(0, 8'd0, v, 4, 0);
    expect_res(0, "t3u", 8'd128, 3'd2, 9'd128);
`endif
    release_res(0);

    // 4: stalls, held result under backpressure, and start ignored in DONE
    v = '{8'd20, 8'd5, 8'd12, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0};
    search(0, 8'd10, v, 4, 3);
    expect_res(0, "t4", 8'd9, 3'd3, 9'd1);
    for (int k = 0; k < 5; k++) begin
      st[0] = (k == 2); rf[0] = 8'd77;
      tick();
      chk("t4_hold_rv",   32'(rv[0]), 1);
      chk("t4_hold_data", 32'(rd[0]), 32'd9);
      chk("t4_hold_dist", 32'(rds[0]), 32'd1);
    end
    st[0] = 1'b0;
    chk("t4_busy_done", 32'(bsy[0]), 1);
    rr[0] = 1'b1; st[0] = 1'b1;
    tick();
    rr[0] = 1'b0; st[0] = 1'b0;
    chk("t4_handoff_start", 32'(bsy[0]), 0);
    chk("t4_handoff_rv",    32'(rv[0]), 0);
    chk("t4_held_data",     32'(rd[0]), 32'd9);
    chk("t4_held_idx",      32'(ri[0]), 32'd3);
    v = '{8'd0, 8'd255, 8'd199, 8'd201, 8'd0, 8'd0, 8'd0, 8'd0};
    search(0, 8'd200, v, 4, 0);
    expect_res(0, "t4b", 8'd199, 3'd2, 9'd1);
    release_res(0);

    // 5: reset mid-SCAN after two accepts
    st[0] = 1'b1; rf[0] = 8'd50;
    tick();
    st[0] = 1'b0; cv[0] = 1'b1; cd[0] = 8'd10;
    tick();
    cd[0] = 8'd20;
    tick();
    cv[0] = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy", 32'(bsy[0]), 0);
    chk("t5_crdy", 32'(crdy[0]), 0);
    chk("t5_rv",   32'(rv[0]), 0);
    chk("t5_data", 32'(rd[0]), 0);
    chk("t5_idx",  32'(ri[0]), 0);
    chk("t5_dist", 32'(rds[0]), 0);
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    search(0, 8'd7, v, 4, 0);
    expect_res(0, "t5b", 8'd4, 3'd3, 9'd3);
    release_res(0);

    // 6: random searches on the N=8 unit, checked against a model
    for (int s = 0; s < 650; s++) begin
      r = 8'($urandom);
      eds = 9'h1FF; ed = 0; ei = 0;
      for (int k = 0; k < 8; k++) begin
        v[k] = 8'($urandom);
        if ((s % 7) == 0) v[k] = r ^ 8'($urandom_range(0, 3));
        dd = mdist(v[k], r);
        if (dd < eds) begin eds = dd; ed = v[k]; ei = 3'(k); end
      end
      search(1, r, v, 8, int'($urandom_range(0, 1)));
      expect_res(1, "rnd", ed, ei, eds);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      release_res(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
